// File: rtl/approx_mul_share_ctrl.sv
// Round-robin controller time-sharing one 8x8 multiplier core among N_REQ requesters.
// Operands are registered into the core; products are captured one cycle later into per-requester buffers.
module approx_mul_share_ctrl #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [8*N_REQ-1:0]    req_x,
  input  logic [8*N_REQ-1:0]    req_y,
  output logic [N_REQ-1:0]      resp_valid,
  input  logic [N_REQ-1:0]      resp_ready,
  output logic [16*N_REQ-1:0]   resp_z,
  output logic [7:0]            mul_x,
  output logic [7:0]            mul_y,
  input  logic [15:0]           mul_z,
  output logic                  busy,
  output logic [15:0]           issue_count
);

  localparam int unsigned DW  = 8;
  localparam int unsigned PW  = 16;
  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] pending;
  logic [IDW-1:0]   ptr;
  logic             iss_v;
  logic [IDW-1:0]   iss_id;
  logic [DW-1:0]    iss_x;
  logic [DW-1:0]    iss_y;

  logic [N_REQ-1:0] eligible;
  logic             gnt_v;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   scan_idx;
  logic [N_REQ-1:0] cap_mask;
  logic [N_REQ-1:0] resp_hs;

  assign eligible = req_valid & ~pending;
  assign resp_hs  = resp_valid & resp_ready;

  // Round-robin search over eligible requesters starting at ptr.
  always_comb begin
    gnt_v     = 1'b0;
    gnt_id    = '0;
    scan_idx  = '0;
    req_ready = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = IDW'((32'(ptr) + k) % N_REQ);
      if (!gnt_v && eligible[scan_idx]) begin
        gnt_v  = 1'b1;
        gnt_id = scan_idx;
      end
    end
    if (gnt_v) begin
      req_ready = N_REQ'(1) << gnt_id;
    end
  end

  always_comb begin
    cap_mask = '0;
    if (iss_v) begin
      cap_mask = N_REQ'(1) << iss_id;
    end
  end

  // Arbitration pointer, pending bits and grant counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      pending     <= '0;
      issue_count <= '0;
    end else begin
      pending <= (pending & ~resp_hs) | req_ready;
      if (gnt_v) begin
        ptr         <= (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);
        issue_count <= issue_count + 16'd1;
      end
    end
  end

  // Issue register feeding the multiplier core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v  <= 1'b0;
      iss_id <= '0;
      iss_x  <= '0;
      iss_y  <= '0;
    end else begin
      iss_v <= gnt_v;
      if (gnt_v) begin
        iss_id <= gnt_id;
        iss_x  <= req_x[DW*32'(gnt_id) +: DW];
        iss_y  <= req_y[DW*32'(gnt_id) +: DW];
      end
    end
  end

  // Result buffers: pending guarantees the target slot is empty on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_z     <= '0;
    end else begin
      resp_valid <= (resp_valid & ~resp_hs) | cap_mask;
      if (iss_v) begin
        resp_z[PW*32'(iss_id) +: PW] <= mul_z;
      end
    end
  end

  assign mul_x = iss_x;
  assign mul_y = iss_y;
  assign busy  = |pending;

endmodule
